pio_led_pwm: RTL and testbench
==============================

Name: pio_led_pwm

Overview:
- Parametrised Avalon-MM output PIO for board LEDs.
- Adds atomic set/clear registers, per-channel blink mode driven by a programmable prescaler, and a global 8-bit PWM brightness control.
- Sits on the system interconnect as a slave; out_port drives the LED pins directly.

Parameters:
- WIDTH, 8: number of LED channels (1..32).
- RESET_VALUE, 0: DATA register value after reset (WIDTH bits).
- PRESCALE_W, 24: width of the blink period register and counter (1..32).
- RESET_PERIOD, 2499999: PERIOD register value after reset.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational, zero wait states.
- out_port  out  WIDTH  registered LED drive.

Behaviour:
- Clock and reset: clk is the clock; reset_n is asynchronous, active-low.
- Write condition: a write occurs when chipselect && !write_n. Only writedata[WIDTH-1:0] is used unless stated otherwise.
- Register map:
  - 0 DATA: r/w.
  - 1 MODE: r/w; bit i=1 selects blink for channel i.
  - 2 OUTSET: write-only; DATA <= DATA | wd.
  - 3 OUTCLEAR: write-only; DATA <= DATA & ~wd.
  - 4 PERIOD: r/w, PRESCALE_W bits.
  - 5 DUTY: r/w, bits 7:0.
  - 6 STATUS: read-only; bit0 = blink_phase, bits 15:8 = pwm_cnt.
  - 7: reserved.
- Reads: readdata = selected register zero-extended to 32 bits. Addresses 2, 3 and 7 read 0. Writes to 6 and 7 are ignored.
- Reset values:
  - DATA = RESET_VALUE.
  - MODE = 0.
  - PERIOD = RESET_PERIOD.
  - DUTY = 8'hFF.
  - presc_cnt = RESET_PERIOD.
  - blink_phase = 0.
  - pwm_cnt = 0.
  - out_port = 0.
- Prescaler:
  - Each cycle: if presc_cnt == 0, then presc_cnt <= PERIOD and blink_phase toggles; else presc_cnt decrements.
  - blink_phase toggles every PERIOD+1 cycles. PERIOD = 0 toggles every cycle.
- PERIOD write:
  - PERIOD and presc_cnt both load writedata[PRESCALE_W-1:0] at the same edge. blink_phase is not reset.
  - If the write coincides with presc_cnt == 0, the write value wins for presc_cnt and blink_phase still toggles.
- PWM counter:
  - pwm_cnt is an 8-bit free-running counter that increments every cycle and wraps 255->0.
  - pwm_on = 1 if DUTY == 8'hFF; otherwise pwm_on = (pwm_cnt < DUTY).
  - DUTY = 0 means always off.
- Output, registered each cycle: out_port[i] <= DATA[i] & (MODE[i] ? blink_phase : 1) & pwm_on.
  - Latency: a DATA/OUTSET/OUTCLEAR/MODE/DUTY write at edge N changes the register at N; out_port reflects it at edge N+1.
- Bits of writedata above WIDTH are ignored. With WIDTH < 32, readdata upper bits are 0.
- Simultaneous events: only one bus access per cycle, so no register write conflicts exist. The prescaler and PWM counters keep running during bus accesses.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); out_port drops to 0 without waiting for clk.

Test Plan:
1. Reset then idle, WIDTH=8, RESET_VALUE=8'hA5, DUTY default -> out_port 0 during reset; 8'hA5 one edge after release; read addr0 = 32'h000000A5.
2. Write DATA=8'h0F, OUTSET=8'hF0, OUTCLEAR=8'h81 on consecutive cycles -> DATA 0F, FF, 7E; out_port follows each one cycle later; reads of addr2/3 = 0.
3. PERIOD=3, MODE=8'h01, DATA=8'h01 -> blink_phase toggles every 4 cycles; out_port[0] is high 4 cycles and low 4 cycles, starting from the toggle that follows the write; STATUS bit0 matches.
4. DUTY=64, DATA=8'hFF, MODE=0 -> out_port=FF for exactly 64 of every 256 cycles, while pwm_cnt 0..63 (one-cycle lag). DUTY=0 -> always 0. DUTY=255 -> always FF.
5. PERIOD write landing on the presc_cnt==0 cycle, PERIOD=5 -> phase toggles that edge; next toggle exactly 6 cycles later.
6. Assert reset_n mid-blink with PWM active -> out_port=0 asynchronously; registers return to reset values; blink and PWM restart from phase 0 and pwm_cnt 0.

Source files
------------

// File: rtl/pio_led_pwm.sv
`default_nettype none
// ============================================================================
// Module   : pio_led_pwm
// Purpose  : Avalon-MM output PIO for board LEDs. Adds atomic set/clear of the
//            DATA register, per-channel blink driven by a programmable
//            prescaler, and a global 8-bit PWM brightness control.
// Ports    : clk, reset_n          - clock, asynchronous active-low reset
//            address[2:0]          - word address of the register
//            chipselect, write_n   - slave select, active-low write strobe
//            writedata[31:0]       - write data
//            readdata[31:0]        - combinational read data (zero wait)
//            out_port[WIDTH-1:0]   - registered LED drive
// Register map:
//            0 DATA  1 MODE  2 OUTSET(wo)  3 OUTCLEAR(wo)
//            4 PERIOD  5 DUTY  6 STATUS(ro: bit0 phase, 15:8 pwm_cnt)  7 rsvd
// Revision : 1.0 - initial release
// ============================================================================
module pio_led_pwm #(
  parameter int unsigned      WIDTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter int unsigned      PRESCALE_W   = 24,
  parameter logic [31:0]      RESET_PERIOD = 32'd2499999
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [PRESCALE_W-1:0] c_reset_period = RESET_PERIOD[PRESCALE_W-1:0];

  logic [WIDTH-1:0]      r_data;
  logic [WIDTH-1:0]      r_mode;
  logic [PRESCALE_W-1:0] r_period;
  logic [7:0]            r_duty;
  logic [PRESCALE_W-1:0] r_presc_cnt;
  logic                  r_blink_phase;
  logic [7:0]            r_pwm_cnt;

  logic                  w_wr;
  logic [WIDTH-1:0]      w_wd;
  logic                  w_presc_zero;
  logic                  w_pwm_on;
  logic [WIDTH-1:0]      w_blink_mask;
  logic                  w_unused;

  assign w_wr         = chipselect && !write_n;
  assign w_wd         = writedata[WIDTH-1:0];
  assign w_presc_zero = (r_presc_cnt == '0);
  // Full-scale duty is a special case so that 255 means "always on" rather
  // than "on for 255 of 256 cycles".
  assign w_pwm_on     = (r_duty == 8'hFF) || (r_pwm_cnt < r_duty);
  // Steady channels pass straight through; blinking channels follow the phase.
  assign w_blink_mask = ~r_mode | {WIDTH{r_blink_phase}};
  // Upper writedata bits are intentionally ignored.
  assign w_unused     = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data        <= RESET_VALUE;
      r_mode        <= '0;
      r_period      <= c_reset_period;
      r_duty        <= 8'hFF;
      r_presc_cnt   <= c_reset_period;
      r_blink_phase <= 1'b0;
      r_pwm_cnt     <= 8'd0;
      out_port      <= '0;
    end else begin
      if (w_wr) begin
        case (address)
          3'd0:    r_data   <= w_wd;
          3'd1:    r_mode   <= w_wd;
          3'd2:    r_data   <= r_data | w_wd;
          3'd3:    r_data   <= r_data & ~w_wd;
          3'd4:    r_period <= writedata[PRESCALE_W-1:0];
          3'd5:    r_duty   <= writedata[7:0];
          default: ;
        endcase
      end

      // A PERIOD write restarts the countdown with the new value; a terminal
      // count on the same edge still toggles the phase.
      if (w_wr && (address == 3'd4)) begin
        r_presc_cnt <= writedata[PRESCALE_W-1:0];
      end else if (w_presc_zero) begin
        r_presc_cnt <= r_period;
      end else begin
        r_presc_cnt <= r_presc_cnt - 1'b1;
      end

      if (w_presc_zero) begin
        r_blink_phase <= ~r_blink_phase;
      end

      r_pwm_cnt <= r_pwm_cnt + 8'd1;

      // Uses pre-write register values, so bus writes show up one edge later.
      out_port <= r_data & w_blink_mask & {WIDTH{w_pwm_on}};
    end
  end

  always_comb begin
    readdata = 32'd0;
    case (address)
      3'd0:    readdata[WIDTH-1:0]      = r_data;
      3'd1:    readdata[WIDTH-1:0]      = r_mode;
      3'd4:    readdata[PRESCALE_W-1:0] = r_period;
      3'd5:    readdata[7:0]            = r_duty;
      3'd6:    readdata                 = {16'd0, r_pwm_cnt, 7'd0, r_blink_phase};
      default: readdata                 = 32'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_pio_led_pwm.sv
`default_nettype none
// ============================================================================
// Module   : tb_pio_led_pwm
// Purpose  : Scoreboard bench for pio_led_pwm. The driver advances a
//            schedule-based reference model on every clock edge and queues the
//            expected out_port / readdata; a monitor pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pio_led_pwm;

  localparam int          W     = 8;
  localparam int          PW    = 24;
  localparam int          RP    = 20;
  localparam logic [7:0]  RV    = 8'hA5;
  localparam logic [31:0] PMASK = (PW >= 32) ? 32'hFFFF_FFFF : ((32'd1 << PW) - 32'd1);

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [2:0]   address = 3'd0;
  logic         chipselect = 1'b0;
  logic         write_n = 1'b1;
  logic [31:0]  writedata = 32'd0;
  logic [31:0]  readdata;
  logic [W-1:0] out_port;

  pio_led_pwm #(
    .WIDTH        (W),
    .RESET_VALUE  (RV),
    .PRESCALE_W   (PW),
    .RESET_PERIOD (RP)
  ) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: architectural registers plus an absolute edge index and
  // the edge number at which the blink phase next flips.
  logic [W-1:0] m_data, m_mode;
  logic [31:0]  m_period;
  logic [7:0]   m_duty;
  bit           m_phase;
  longint       m_k;
  longint       m_next;

  // Bus values currently presented to the DUT.
  bit           b_cs, b_wn;
  logic [2:0]   b_addr;
  logic [31:0]  b_wd;

  logic [W-1:0] out_q[$];
  logic [31:0]  rd_q[$];
  logic [W-1:0] mon_out;
  logic [31:0]  mon_rd;

  function automatic void model_reset();
    m_data   = RV;
    m_mode   = '0;
    m_period = RP;
    m_duty   = 8'hFF;
    m_phase  = 1'b0;
    m_k      = 0;
    m_next   = RP + 1;
  endfunction

  function automatic logic [31:0] exp_read(input logic [2:0] a);
    logic [31:0] r;
    r = 32'd0;
    case (a)
      3'd0:    r = 32'(m_data);
      3'd1:    r = 32'(m_mode);
      3'd4:    r = m_period;
      3'd5:    r = 32'(m_duty);
      3'd6:    r = {16'd0, 8'(m_k % 256), 7'd0, m_phase};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Called right after a rising edge: predicts out_port for that edge from
  // the state before it, then applies the bus write and timing events.
  function automatic void model_step();
    logic [W-1:0] e;
    bit           on, tog, pw;
    int           cnt;
    cnt = int'(m_k % 256);
    on  = (m_duty == 8'hFF) || (cnt < int'(m_duty));
    for (int i = 0; i < W; i++)
      e[i] = m_data[i] && (!m_mode[i] || m_phase) && on;
    out_q.push_back(e);
    m_k = m_k + 1;
    tog = (m_k == m_next);
    pw  = b_cs && !b_wn && (b_addr == 3'd4);
    if (b_cs && !b_wn) begin
      case (b_addr)
        3'd0:    m_data   = b_wd[W-1:0];
        3'd1:    m_mode   = b_wd[W-1:0];
        3'd2:    m_data   = m_data | b_wd[W-1:0];
        3'd3:    m_data   = m_data & ~b_wd[W-1:0];
        3'd4:    m_period = b_wd & PMASK;
        3'd5:    m_duty   = b_wd[7:0];
        default: ;
      endcase
    end
    if (tog) m_phase = !m_phase;
    if (pw || tog) m_next = m_k + longint'(m_period) + 1;
  endfunction

  task automatic drive(input bit cs, input bit wn, input logic [2:0] a, input logic [31:0] d);
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = d;
    b_cs = cs; b_wn = wn; b_addr = a; b_wd = d;
    if (cs && wn) rd_q.push_back(exp_read(a));
  endtask

  task automatic cycle_op(input bit cs, input bit wn, input logic [2:0] a, input logic [31:0] d);
    @(posedge clk);
    model_step();
    #1;
    drive(cs, wn, a, d);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle_op(1'b0, 1'b1, 3'd0, 32'd0);
  endtask

  task automatic rand_cycle();
    int          r;
    logic [2:0]  a;
    logic [31:0] d;
    @(posedge clk);
    model_step();
    #1;
    r = $urandom_range(0, 99);
    a = 3'($urandom_range(0, 7));
    d = $urandom;
    if ((m_k + 1 == m_next) && ($urandom_range(0, 1) == 1)) begin
      // Land a PERIOD write exactly on the terminal-count edge.
      drive(1'b1, 1'b0, 3'd4, 32'($urandom_range(0, 9)));
    end else if (r < 5) begin
      drive(1'b0, 1'b0, a, d);
    end else if (r < 35) begin
      drive(1'b0, 1'b1, a, d);
    end else if (r < 65) begin
      drive(1'b1, 1'b1, a, d);
    end else begin
      if (a == 3'd4 && $urandom_range(0, 7) != 0) d = 32'($urandom_range(0, 12));
      if (a == 3'd5) begin
        case ($urandom_range(0, 3))
          0:       d = 32'h0;
          1:       d = 32'hFF;
          2:       d = 32'd64;
          default: d = $urandom;
        endcase
      end
      drive(1'b1, 1'b0, a, d);
    end
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (out_q.size() > 0) begin
        mon_out = out_q.pop_front();
        checks++;
        if (out_port !== mon_out) begin
          failures++;
          $display("FAIL out_port t=%0t got=%h exp=%h", $time, out_port, mon_out);
        end
      end
      if (rd_q.size() > 0) begin
        mon_rd = rd_q.pop_front();
        checks++;
        if (readdata !== mon_rd) begin
          failures++;
          $display("FAIL readdata addr=%0d t=%0t got=%h exp=%h", address, $time, readdata, mon_rd);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    drive(1'b1, 1'b1, 3'd0, 32'd0);       // read DATA while in reset
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_port !== '0) begin
      failures++;
      $display("FAIL reset_out got=%h exp=%h", out_port, {W{1'b0}});
    end
    @(negedge clk);
    #2;
    drive(1'b0, 1'b1, 3'd0, 32'd0);
    reset_n = 1'b1;

    // Idle past the first reset-period toggle
    idle(30);
    // DATA / OUTSET / OUTCLEAR and write-only reads
    cycle_op(1'b1, 1'b0, 3'd0, 32'h0F);
    cycle_op(1'b1, 1'b0, 3'd2, 32'hF0);
    cycle_op(1'b1, 1'b0, 3'd3, 32'hFFFF_FF81);
    cycle_op(1'b1, 1'b1, 3'd2, 32'd0);
    cycle_op(1'b1, 1'b1, 3'd3, 32'd0);
    cycle_op(1'b1, 1'b1, 3'd0, 32'd0);
    // Blink with PERIOD=3
    cycle_op(1'b1, 1'b0, 3'd4, 32'd3);
    cycle_op(1'b1, 1'b0, 3'd1, 32'h01);
    cycle_op(1'b1, 1'b0, 3'd0, 32'h01);
    repeat (20) cycle_op(1'b1, 1'b1, 3'd6, 32'd0);
    // PWM duty 64, then 0, then 255
    cycle_op(1'b1, 1'b0, 3'd5, 32'd64);
    cycle_op(1'b1, 1'b0, 3'd0, 32'hFF);
    cycle_op(1'b1, 1'b0, 3'd1, 32'h00);
    idle(600);
    cycle_op(1'b1, 1'b0, 3'd5, 32'd0);
    idle(50);
    cycle_op(1'b1, 1'b0, 3'd5, 32'd255);
    idle(20);
    // Randomized traffic
    repeat (3000) rand_cycle();

    // Reset mid-operation with blink and PWM active
    cycle_op(1'b1, 1'b0, 3'd0, 32'hFF);
    cycle_op(1'b1, 1'b0, 3'd1, 32'h0F);
    cycle_op(1'b1, 1'b0, 3'd4, 32'd2);
    cycle_op(1'b1, 1'b0, 3'd5, 32'd200);
    idle(5);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_port !== '0) begin
      failures++;
      $display("FAIL async_reset_out got=%h exp=%h", out_port, {W{1'b0}});
    end
    model_reset();
    drive(1'b1, 1'b1, 3'd4, 32'd0);
    @(negedge clk);
    #2;
    drive(1'b1, 1'b1, 3'd5, 32'd0);
    @(negedge clk);
    #2;
    drive(1'b1, 1'b1, 3'd6, 32'd0);
    @(negedge clk);
    #2;
    drive(1'b0, 1'b1, 3'd0, 32'd0);
    reset_n = 1'b1;
    idle(30);
    repeat (500) rand_cycle();
    idle(2);

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (out_q.size() != 0 || rd_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain got=%0d/%0d exp=0/0", out_q.size(), rd_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
